id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 64-bit five-stage core. It sits directly downstream of the register file. It captures the register-file read data, the immediate and the decoded control for one instruction per cycle, and bypasses same-cycle write-back data that the register file has not yet committed. It also detects load-use and branch-in-ID hazards, inserts bubbles, drives the PC/IF-ID stall, and resolves the ID-stage branch compare on forwarded operands.

## Interface
- DATA_W, 64, datapath width
- ADDR_W, 64, PC width
- clk_i  in  1  clock, rising edge
- nrst_i  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID holds a real instruction
- pc_addr_i  in  ADDR_W  PC of ID instruction
- RSaddr_i, RTaddr_i, RDaddr_i  in  5 each  ID register addresses
- use_rs_i, use_rt_i  in  1 each  instruction actually reads rs / rt
- RSdata_i, RTdata_i  in  DATA_W each  register-file read data
- imm_i  in  DATA_W  sign-extended immediate
- RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i, Branch_i  in  1 each  decoded control
- ALUOp_i  in  4  ALU operation
- flush_i  in  1  kill the ID instruction (taken branch / redirect)
- mem_RegWrite_i, mem_MemRead_i  in  1 each  MEM-stage control
- mem_RDaddr_i  in  5  MEM-stage destination
- mem_alu_i  in  DATA_W  MEM-stage ALU result
- wb_RegWrite_i  in  1  WB write enable (same as register-file write enable)
- wb_RDaddr_i  in  5  WB destination
- wb_RDdata_i  in  DATA_W  WB data
- stall_o  out  1  hold PC and IF/ID this cycle
- branch_equal_o  out  1  forwarded rs == rt, for the ID branch decision
- ex_valid_o  out  1  EX slot holds a real instruction
- ex_pc_o  out  ADDR_W  registered PC
- ex_RSdata_o, ex_RTdata_o, ex_imm_o  out  DATA_W each  registered operands
- ex_RSaddr_o, ex_RTaddr_o, ex_RDaddr_o  out  5 each  registered addresses
- ex_RegWrite_o, ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o, ex_ALUSrc_o  out  1 each  registered control
- ex_ALUOp_o  out  4  registered ALU operation
- stall_cnt_o  out  32  saturating count of stall cycles

## Operation
- Match terms (combinational): a match against X means X_RD != 0, X_RD equals an address, and the matching use_*_i is set.
- WB bypass: if wb_RegWrite_i and wb_RDaddr_i matches RSaddr_i (≠0), the rs operand becomes wb_RDdata_i, else RSdata_i. rt is handled identically. The bypass covers the register file's write-then-read-old-value behaviour in the same cycle.
- Branch operands: MEM forwarding has priority over WB. If mem_RegWrite_i, !mem_MemRead_i and mem_RDaddr_i matches, use mem_alu_i. Otherwise use the WB-bypassed value. branch_equal_o compares the two results.
- Hazards, all qualified by id_valid_i:
  - load_use = ex_valid_o & ex_MemRead_o & match(ex_RDaddr_o, rs|rt)
  - br_ex = Branch_i & ex_valid_o & ex_RegWrite_o & match(ex_RDaddr_o, rs|rt)
  - br_mem = Branch_i & mem_MemRead_i & match(mem_RDaddr_i, rs|rt)
  - stall_o = (load_use | br_ex | br_mem) & !flush_i
- Capture per rising edge, in priority order:
  1. flush_i or stall_o or !id_valid_i: load a bubble. ex_valid_o=0, all ex_ control fields=0, ex_RDaddr_o=0. Data fields are don't-care; they hold 0.
  2. Otherwise: load the bypassed operands, addresses, imm, pc and control, with ex_valid_o=1.
- stall_cnt_o increments on each cycle with stall_o=1 and saturates at 0xFFFF_FFFF.
- Register 0 is never a hazard source and is never forwarded.

## Timing
- Reset (nrst_i low, asynchronous): every ex_ output is 0, ex_valid_o=0 and stall_cnt_o=0. stall_o and branch_equal_o follow their combinational inputs.
- Latency: one cycle from ID inputs to ex_ outputs.
- stall_o is combinational in the same cycle.
- Load-use produces exactly one bubble: the next cycle ex_MemRead_o=0, so the hazard clears.
- A branch after an ALU producer stalls 1 cycle.
- A branch after a load stalls 2 cycles (br_ex, then br_mem).
- Flush and stall asserted together: a bubble is inserted and stall_o=0.
- Reset released mid-stream: the first post-reset edge captures normally.

## Test plan
- Reset: nrst_i=0 mid-cycle -> all ex_ outputs 0 and stall_cnt_o=0 immediately, with no clock edge needed.
- WB bypass: RSaddr_i=5, RSdata_i=0x11, wb write r5=0xAA in the same cycle -> ex_RSdata_o=0xAA next cycle. With wb_RDaddr_i=0 -> ex_RSdata_o=0x11.
- Load-use: EX holds a load to r7; ID reads r7 with use_rs_i=1 -> stall_o=1 for one cycle, one bubble (ex_valid_o=0), then normal capture; stall_cnt_o=1.
- Branch after load: a load to r3 followed by a beq r3,r4 -> stall_o high for 2 cycles. branch_equal_o is then valid from WB bypass data; stall_cnt_o=2.
- Branch MEM forward: mem_alu_i=0x40 to r2, RSaddr_i=2, RTdata_i=0x40 -> branch_equal_o=1 with no stall.
- Flush priority: flush_i=1 together with a load-use condition -> stall_o=0, bubble captured, stall_cnt_o unchanged.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass, hazard detection and ID branch compare
// Bubbles zero the control and data fields so a flushed or stalled slot can never write state.
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] pc_addr_i,
  input  logic [4:0]        RSaddr_i,
  input  logic [4:0]        RTaddr_i,
  input  logic [4:0]        RDaddr_i,
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  input  logic              ALUSrc_i,
  input  logic              Branch_i,
  input  logic [3:0]        ALUOp_i,
  input  logic              flush_i,
  input  logic              mem_RegWrite_i,
  input  logic              mem_MemRead_i,
  input  logic [4:0]        mem_RDaddr_i,
  input  logic [DATA_W-1:0] mem_alu_i,
  input  logic              wb_RegWrite_i,
  input  logic [4:0]        wb_RDaddr_i,
  input  logic [DATA_W-1:0] wb_RDdata_i,
  output logic              stall_o,
  output logic              branch_equal_o,
  output logic              ex_valid_o,
  output logic [ADDR_W-1:0] ex_pc_o,
  output logic [DATA_W-1:0] ex_RSdata_o,
  output logic [DATA_W-1:0] ex_RTdata_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_RSaddr_o,
  output logic [4:0]        ex_RTaddr_o,
  output logic [4:0]        ex_RDaddr_o,
  output logic              ex_RegWrite_o,
  output logic              ex_MemRead_o,
  output logic              ex_MemWrite_o,
  output logic              ex_MemtoReg_o,
  output logic              ex_ALUSrc_o,
  output logic [3:0]        ex_ALUOp_o,
  output logic [31:0]       stall_cnt_o
);

  logic              r_ex_valid;
  logic [ADDR_W-1:0] r_ex_pc;
  logic [DATA_W-1:0] r_ex_rs_data, r_ex_rt_data, r_ex_imm;
  logic [4:0]        r_ex_rs_addr, r_ex_rt_addr, r_ex_rd_addr;
  logic              r_ex_reg_write, r_ex_mem_read, r_ex_mem_write, r_ex_mem_to_reg, r_ex_alu_src;
  logic [3:0]        r_ex_alu_op;
  logic [31:0]       r_stall_cnt;

  function automatic logic f_match(input logic [4:0] rd, input logic [4:0] addr, input logic en);
    return en && (rd != 5'd0) && (rd == addr);
  endfunction

  logic              w_rs_wb_hit, w_rt_wb_hit, w_rs_mem_hit, w_rt_mem_hit;
  logic [DATA_W-1:0] w_rs_byp, w_rt_byp, w_rs_br, w_rt_br;
  logic              w_ex_hit, w_mem_hit, w_load_use, w_br_ex, w_br_mem, w_bubble;

  // WB bypass covers the register file returning the old value on a same-cycle write.
  assign w_rs_wb_hit  = wb_RegWrite_i && f_match(wb_RDaddr_i, RSaddr_i, use_rs_i);
  assign w_rt_wb_hit  = wb_RegWrite_i && f_match(wb_RDaddr_i, RTaddr_i, use_rt_i);
  assign w_rs_byp     = w_rs_wb_hit ? wb_RDdata_i : RSdata_i;
  assign w_rt_byp     = w_rt_wb_hit ? wb_RDdata_i : RTdata_i;

  assign w_rs_mem_hit = mem_RegWrite_i && !mem_MemRead_i && f_match(mem_RDaddr_i, RSaddr_i, use_rs_i);
  assign w_rt_mem_hit = mem_RegWrite_i && !mem_MemRead_i && f_match(mem_RDaddr_i, RTaddr_i, use_rt_i);
  assign w_rs_br      = w_rs_mem_hit ? mem_alu_i : w_rs_byp;
  assign w_rt_br      = w_rt_mem_hit ? mem_alu_i : w_rt_byp;
  assign branch_equal_o = (w_rs_br == w_rt_br);

  assign w_ex_hit   = f_match(r_ex_rd_addr, RSaddr_i, use_rs_i) || f_match(r_ex_rd_addr, RTaddr_i, use_rt_i);
  assign w_mem_hit  = f_match(mem_RDaddr_i, RSaddr_i, use_rs_i) || f_match(mem_RDaddr_i, RTaddr_i, use_rt_i);
  assign w_load_use = id_valid_i && r_ex_valid && r_ex_mem_read && w_ex_hit;
  assign w_br_ex    = id_valid_i && Branch_i && r_ex_valid && r_ex_reg_write && w_ex_hit;
  assign w_br_mem   = id_valid_i && Branch_i && mem_MemRead_i && w_mem_hit;
  assign stall_o    = (w_load_use || w_br_ex || w_br_mem) && !flush_i;
  assign w_bubble   = flush_i || stall_o || !id_valid_i;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_ex_valid      <= 1'b0;
      r_ex_pc         <= '0;
      r_ex_rs_data    <= '0;
      r_ex_rt_data    <= '0;
      r_ex_imm        <= '0;
      r_ex_rs_addr    <= '0;
      r_ex_rt_addr    <= '0;
      r_ex_rd_addr    <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_ex_alu_op     <= '0;
      r_stall_cnt     <= '0;
    end else begin
      if (w_bubble) begin
        r_ex_valid      <= 1'b0;
        r_ex_pc         <= '0;
        r_ex_rs_data    <= '0;
        r_ex_rt_data    <= '0;
        r_ex_imm        <= '0;
        r_ex_rs_addr    <= '0;
        r_ex_rt_addr    <= '0;
        r_ex_rd_addr    <= '0;
        r_ex_reg_write  <= 1'b0;
        r_ex_mem_read   <= 1'b0;
        r_ex_mem_write  <= 1'b0;
        r_ex_mem_to_reg <= 1'b0;
        r_ex_alu_src    <= 1'b0;
        r_ex_alu_op     <= '0;
      end else begin
        r_ex_valid      <= 1'b1;
        r_ex_pc         <= pc_addr_i;
        r_ex_rs_data    <= w_rs_byp;
        r_ex_rt_data    <= w_rt_byp;
        r_ex_imm        <= imm_i;
        r_ex_rs_addr    <= RSaddr_i;
        r_ex_rt_addr    <= RTaddr_i;
        r_ex_rd_addr    <= RDaddr_i;
        r_ex_reg_write  <= RegWrite_i;
        r_ex_mem_read   <= MemRead_i;
        r_ex_mem_write  <= MemWrite_i;
        r_ex_mem_to_reg <= MemtoReg_i;
        r_ex_alu_src    <= ALUSrc_i;
        r_ex_alu_op     <= ALUOp_i;
      end
      if (stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign ex_valid_o    = r_ex_valid;
  assign ex_pc_o       = r_ex_pc;
  assign ex_RSdata_o   = r_ex_rs_data;
  assign ex_RTdata_o   = r_ex_rt_data;
  assign ex_imm_o      = r_ex_imm;
  assign ex_RSaddr_o   = r_ex_rs_addr;
  assign ex_RTaddr_o   = r_ex_rt_addr;
  assign ex_RDaddr_o   = r_ex_rd_addr;
  assign ex_RegWrite_o = r_ex_reg_write;
  assign ex_MemRead_o  = r_ex_mem_read;
  assign ex_MemWrite_o = r_ex_mem_write;
  assign ex_MemtoReg_o = r_ex_mem_to_reg;
  assign ex_ALUSrc_o   = r_ex_alu_src;
  assign ex_ALUOp_o    = r_ex_alu_op;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        id_valid_i;
  logic [63:0] pc_addr_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
  logic        use_rs_i, use_rt_i;
  logic [63:0] RSdata_i, RTdata_i, imm_i;
  logic        RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i, Branch_i;
  logic [3:0]  ALUOp_i;
  logic        flush_i;
  logic        mem_RegWrite_i, mem_MemRead_i;
  logic [4:0]  mem_RDaddr_i;
  logic [63:0] mem_alu_i;
  logic        wb_RegWrite_i;
  logic [4:0]  wb_RDaddr_i;
  logic [63:0] wb_RDdata_i;
  logic        stall_o, branch_equal_o, ex_valid_o;
  logic [63:0] ex_pc_o, ex_RSdata_o, ex_RTdata_o, ex_imm_o;
  logic [4:0]  ex_RSaddr_o, ex_RTaddr_o, ex_RDaddr_o;
  logic        ex_RegWrite_o, ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o, ex_ALUSrc_o;
  logic [3:0]  ex_ALUOp_o;
  logic [31:0] stall_cnt_o;

  int total = 0;
  int bad = 0;

  id_ex_stage #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .id_valid_i(id_valid_i), .pc_addr_i(pc_addr_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
    .use_rs_i(use_rs_i), .use_rt_i(use_rt_i), .RSdata_i(RSdata_i), .RTdata_i(RTdata_i),
    .imm_i(imm_i), .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemtoReg_i(MemtoReg_i), .ALUSrc_i(ALUSrc_i), .Branch_i(Branch_i), .ALUOp_i(ALUOp_i),
    .flush_i(flush_i), .mem_RegWrite_i(mem_RegWrite_i), .mem_MemRead_i(mem_MemRead_i),
    .mem_RDaddr_i(mem_RDaddr_i), .mem_alu_i(mem_alu_i), .wb_RegWrite_i(wb_RegWrite_i),
    .wb_RDaddr_i(wb_RDaddr_i), .wb_RDdata_i(wb_RDdata_i), .stall_o(stall_o),
    .branch_equal_o(branch_equal_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_RSdata_o(ex_RSdata_o), .ex_RTdata_o(ex_RTdata_o), .ex_imm_o(ex_imm_o),
    .ex_RSaddr_o(ex_RSaddr_o), .ex_RTaddr_o(ex_RTaddr_o), .ex_RDaddr_o(ex_RDaddr_o),
    .ex_RegWrite_o(ex_RegWrite_o), .ex_MemRead_o(ex_MemRead_o), .ex_MemWrite_o(ex_MemWrite_o),
    .ex_MemtoReg_o(ex_MemtoReg_o), .ex_ALUSrc_o(ex_ALUSrc_o), .ex_ALUOp_o(ex_ALUOp_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic id_clear();
    id_valid_i = 1'b1; pc_addr_i = '0;
    RSaddr_i = '0; RTaddr_i = '0; RDaddr_i = '0; use_rs_i = 1'b0; use_rt_i = 1'b0;
    RSdata_i = '0; RTdata_i = '0; imm_i = '0;
    RegWrite_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; MemtoReg_i = 1'b0;
    ALUSrc_i = 1'b0; Branch_i = 1'b0; ALUOp_i = '0; flush_i = 1'b0;
  endtask

  task automatic fwd_clear();
    mem_RegWrite_i = 1'b0; mem_MemRead_i = 1'b0; mem_RDaddr_i = '0; mem_alu_i = '0;
    wb_RegWrite_i = 1'b0; wb_RDaddr_i = '0; wb_RDdata_i = '0;
  endtask

  initial begin
    nrst_i = 1'b0;
    id_clear();
    id_valid_i = 1'b0;
    fwd_clear();
    #2;
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    #4 nrst_i = 1'b1;

    // normal capture on first post-reset edge
    id_clear();
    pc_addr_i = 64'h100; RSaddr_i = 1; RTaddr_i = 2; RDaddr_i = 3; use_rs_i = 1; use_rt_i = 1;
    RSdata_i = 64'h1111; RTdata_i = 64'h2222; imm_i = 64'h33;
    RegWrite_i = 1; ALUSrc_i = 1; ALUOp_i = 4'h5;
    step();
    chk("cap_valid", ex_valid_o, 1);
    chk("cap_pc", ex_pc_o, 64'h100);
    chk("cap_rs", ex_RSdata_o, 64'h1111);
    chk("cap_rt", ex_RTdata_o, 64'h2222);
    chk("cap_imm", ex_imm_o, 64'h33);
    chk("cap_rd", ex_RDaddr_o, 3);
    chk("cap_regw", ex_RegWrite_o, 1);
    chk("cap_alusrc", ex_ALUSrc_o, 1);
    chk("cap_aluop", ex_ALUOp_o, 4'h5);
    chk("cap_memrd", ex_MemRead_o, 0);

    // WB bypass on rs
    id_clear();
    RSaddr_i = 5; RTaddr_i = 6; RDaddr_i = 8; use_rs_i = 1; use_rt_i = 1;
    RSdata_i = 64'h11; RTdata_i = 64'h66; RegWrite_i = 1;
    wb_RegWrite_i = 1; wb_RDaddr_i = 5; wb_RDdata_i = 64'hAA;
    #1 chk("byp_nostall", stall_o, 0);
    step();
    chk("byp_rs", ex_RSdata_o, 64'hAA);
    chk("byp_rt_plain", ex_RTdata_o, 64'h66);

    // WB to r0 is not forwarded
    wb_RDaddr_i = 0;
    step();
    chk("byp_r0", ex_RSdata_o, 64'h11);

    // WB bypass on rt
    wb_RDaddr_i = 6; wb_RDdata_i = 64'hBB;
    step();
    chk("byp_rt", ex_RTdata_o, 64'hBB);
    chk("byp_rt_rs", ex_RSdata_o, 64'h11);
    fwd_clear();

    // load-use: load r7 then reader of r7
    id_clear();
    RSaddr_i = 1; use_rs_i = 1; RDaddr_i = 7; RegWrite_i = 1; MemRead_i = 1; MemtoReg_i = 1; ALUSrc_i = 1;
    step();
    chk("lu_ex_memrd", ex_MemRead_o, 1);
    chk("lu_ex_m2r", ex_MemtoReg_o, 1);
    id_clear();
    RSaddr_i = 7; RTaddr_i = 2; use_rs_i = 1; use_rt_i = 1; RDaddr_i = 10; RegWrite_i = 1;
    RSdata_i = 64'h7777;
    #1 chk("lu_stall", stall_o, 1);
    step();
    chk("lu_bub_valid", ex_valid_o, 0);
    chk("lu_bub_regw", ex_RegWrite_o, 0);
    chk("lu_bub_rd", ex_RDaddr_o, 0);
    chk("lu_bub_rs", ex_RSdata_o, 0);
    chk("lu_cnt", stall_cnt_o, 1);
    chk("lu_clear", stall_o, 0);
    step();
    chk("lu_cap_valid", ex_valid_o, 1);
    chk("lu_cap_rd", ex_RDaddr_o, 10);
    chk("lu_cap_rs", ex_RSdata_o, 64'h7777);
    chk("lu_cnt2", stall_cnt_o, 1);

    // branch after load: load r3, then beq r3,r4 -> two stall cycles
    id_clear();
    RSaddr_i = 1; use_rs_i = 1; RDaddr_i = 3; RegWrite_i = 1; MemRead_i = 1; MemtoReg_i = 1;
    #1 chk("bl_ld_nostall", stall_o, 0);
    step();
    id_clear();
    Branch_i = 1; RSaddr_i = 3; RTaddr_i = 4; use_rs_i = 1; use_rt_i = 1;
    RSdata_i = 64'h50; RTdata_i = 64'h77;
    mem_RegWrite_i = 1; mem_RDaddr_i = 10; mem_alu_i = 64'h999;
    #1 chk("bl_stall1", stall_o, 1);
    step();
    chk("bl_bub1", ex_valid_o, 0);
    mem_RegWrite_i = 1; mem_MemRead_i = 1; mem_RDaddr_i = 3; mem_alu_i = 64'h0;
    #1 chk("bl_stall2", stall_o, 1);
    step();
    chk("bl_bub2", ex_valid_o, 0);
    chk("bl_cnt", stall_cnt_o, 3);
    fwd_clear();
    wb_RegWrite_i = 1; wb_RDaddr_i = 3; wb_RDdata_i = 64'h77;
    #1 chk("bl_nostall", stall_o, 0);
    chk("bl_beq", branch_equal_o, 1);
    step();
    chk("bl_cap_valid", ex_valid_o, 1);
    chk("bl_cap_rs", ex_RSdata_o, 64'h77);
    chk("bl_cap_regw", ex_RegWrite_o, 0);
    chk("bl_cnt2", stall_cnt_o, 3);
    fwd_clear();

    // branch after ALU producer: one stall, then MEM forward resolves compare
    id_clear();
    RSaddr_i = 1; use_rs_i = 1; RDaddr_i = 2; RegWrite_i = 1;
    step();
    id_clear();
    Branch_i = 1; RSaddr_i = 2; RTaddr_i = 4; use_rs_i = 1; use_rt_i = 1;
    RSdata_i = 64'h0; RTdata_i = 64'h40;
    #1 chk("ba_stall", stall_o, 1);
    step();
    chk("ba_bub", ex_valid_o, 0);
    chk("ba_cnt", stall_cnt_o, 4);
    mem_RegWrite_i = 1; mem_RDaddr_i = 2; mem_alu_i = 64'h40;
    #1 chk("ba_nostall", stall_o, 0);
    chk("ba_beq_mem", branch_equal_o, 1);
    wb_RegWrite_i = 1; wb_RDaddr_i = 2; wb_RDdata_i = 64'h99;
    #1 chk("ba_mem_prio", branch_equal_o, 1);
    mem_alu_i = 64'h41;
    #1 chk("ba_beq_ne", branch_equal_o, 0);
    step();
    chk("ba_cap_valid", ex_valid_o, 1);
    chk("ba_cap_rs_wb", ex_RSdata_o, 64'h99);
    fwd_clear();

    // flush wins over load-use
    id_clear();
    RSaddr_i = 1; use_rs_i = 1; RDaddr_i = 7; RegWrite_i = 1; MemRead_i = 1;
    step();
    id_clear();
    RSaddr_i = 7; use_rs_i = 1; RDaddr_i = 9; RegWrite_i = 1; flush_i = 1;
    #1 chk("fl_nostall", stall_o, 0);
    step();
    chk("fl_bub", ex_valid_o, 0);
    chk("fl_bub_regw", ex_RegWrite_o, 0);
    chk("fl_cnt", stall_cnt_o, 4);

    // load to r0 is never a hazard
    id_clear();
    RSaddr_i = 1; use_rs_i = 1; RDaddr_i = 0; RegWrite_i = 1; MemRead_i = 1;
    step();
    id_clear();
    RSaddr_i = 0; RTaddr_i = 0; use_rs_i = 1; use_rt_i = 1; RDaddr_i = 11; RegWrite_i = 1;
    #1 chk("r0_nostall", stall_o, 0);
    step();
    chk("r0_cap_valid", ex_valid_o, 1);

    // invalid ID slot loads a bubble
    id_clear();
    id_valid_i = 0; RDaddr_i = 12; RegWrite_i = 1; MemWrite_i = 1;
    step();
    chk("inv_valid", ex_valid_o, 0);
    chk("inv_regw", ex_RegWrite_o, 0);
    chk("inv_memw", ex_MemWrite_o, 0);

    // asynchronous reset mid-cycle
    id_clear();
    pc_addr_i = 64'h200; RSaddr_i = 1; use_rs_i = 1; RSdata_i = 64'h5A; RDaddr_i = 13;
    RegWrite_i = 1; ALUOp_i = 4'h3;
    step();
    chk("pre_rst_valid", ex_valid_o, 1);
    #2 nrst_i = 1'b0;
    #1;
    chk("arst_valid", ex_valid_o, 0);
    chk("arst_pc", ex_pc_o, 0);
    chk("arst_rs", ex_RSdata_o, 0);
    chk("arst_rd", ex_RDaddr_o, 0);
    chk("arst_aluop", ex_ALUOp_o, 0);
    chk("arst_cnt", stall_cnt_o, 0);
    nrst_i = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
